spike_class_decoder: RTL

SPIKE_CLASS_DECODER -- requirements
Module: spike_class_decoder

---
 rtl/spike_class_decoder_pkg.sv | 16 +
 rtl/spike_class_decoder_if.sv | 26 ++
 rtl/spike_class_decoder_sat_counter.sv | 26 ++
 rtl/spike_class_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/spike_class_decoder_pkg.sv
// Shared types and helpers for the spiking-network output decoder blocks.
package snn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StScan,
        StDone
    } state_e;

    // Class index width: max(1, clog2(n)).
    function automatic int unsigned class_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_class_decoder_if.sv
// Control/result bundle between a window controller and the spike class decoder.
interface spike_class_decoder_if #(
    parameter int unsigned N_OUT   = 6,
    parameter int unsigned WIN_W   = 16,
    parameter int unsigned CLASS_W = snn_pkg::class_w(N_OUT)
);
    logic               start;
    logic [WIN_W-1:0]   win_len;
    logic               mode;
    logic               step;
    logic [N_OUT-1:0]   out_spk;
    logic               busy;
    logic               end_process;
    logic [CLASS_W-1:0] output_class;
    logic               no_spike;

    modport master (
        output start, win_len, mode, step, out_spk,
        input  busy, end_process, output_class, no_spike
    );

    modport slave (
        input  start, win_len, mode, step, out_spk,
        output busy, end_process, output_class, no_spike
    );
endinterface

// File: rtl/spike_class_decoder_sat_counter.sv
// Per-channel spike counter: synchronous clear, increment enable, sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/spike_class_decoder.sv
// Decides the winning output neuron over a timestep window, either by max spike
// count (serial scan) or by time-to-first-spike.
module spike_class_decoder
    import snn_pkg::*;
#(
    parameter int unsigned N_OUT = 6,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input logic                   clk,
    input logic                   resetn,
    spike_class_decoder_if.slave  bus
);

    localparam int unsigned CLASS_W = class_w(N_OUT);
    localparam logic [CLASS_W-1:0] LastIdx = CLASS_W'(N_OUT - 1);

    state_e             r_state;
    logic [WIN_W-1:0]   r_win_len;
    logic [WIN_W-1:0]   r_step_cnt;
    logic               r_mode;
    logic               r_busy;
    logic               r_end_process;
    logic               r_no_spike;
    logic [CLASS_W-1:0] r_output_class;
    logic [CLASS_W-1:0] r_scan_idx;
    logic [CLASS_W-1:0] r_best;
    logic [CNT_W-1:0]   r_max;

    logic [CNT_W-1:0]   w_cnt [N_OUT];
    logic [N_OUT-1:0]   w_inc;
    logic               w_accept;
    logic [WIN_W-1:0]   w_step_nxt;
    logic [CLASS_W-1:0] w_first_idx;
    logic [CNT_W-1:0]   w_cur;
    logic               w_gt;
    logic [CLASS_W-1:0] w_best_fin;
    logic [CNT_W-1:0]   w_max_fin;

    assign w_accept   = ((r_state == StIdle) || (r_state == StDone)) && bus.start;
    assign w_inc      = ((r_state == StCount) && bus.step) ? bus.out_spk : '0;
    assign w_step_nxt = r_step_cnt + 1'b1;

    for (genvar g = 0; g < N_OUT; g++) begin : g_ch
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (resetn),
            .i_clr (w_accept),
            .i_inc (w_inc[g]),
            .o_cnt (w_cnt[g])
        );
    end

    // Descending walk so the lowest set index is the one left standing.
    always_comb begin
        w_first_idx = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (bus.out_spk[i]) begin
                w_first_idx = CLASS_W'(i);
            end
        end
    end

    // Strictly-greater replacement keeps ties on the lower index.
    always_comb begin
        w_cur      = w_cnt[r_scan_idx];
        w_gt       = (w_cur > r_max);
        w_best_fin = w_gt ? r_scan_idx : r_best;
        w_max_fin  = w_gt ? w_cur : r_max;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= StIdle;
            r_win_len      <= '0;
            r_step_cnt     <= '0;
            r_mode         <= 1'b0;
            r_busy         <= 1'b0;
            r_end_process  <= 1'b0;
            r_no_spike     <= 1'b0;
            r_output_class <= '0;
            r_scan_idx     <= '0;
            r_best         <= '0;
            r_max          <= '0;
        end else begin
            r_end_process <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_win_len  <= bus.win_len;
                        r_mode     <= bus.mode;
                        r_step_cnt <= '0;
                        r_scan_idx <= '0;
                        r_best     <= '0;
                        r_max      <= '0;
                        if (bus.win_len == '0) begin
                            r_state        <= StDone;
                            r_end_process  <= 1'b1;
                            r_no_spike     <= 1'b1;
                            r_output_class <= '0;
                        end else begin
                            r_state <= StCount;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                StCount: begin
                    if (bus.step) begin
                        r_step_cnt <= w_step_nxt;
                        if (r_mode && (bus.out_spk != '0)) begin
                            r_state        <= StDone;
                            r_busy         <= 1'b0;
                            r_end_process  <= 1'b1;
                            r_no_spike     <= 1'b0;
                            r_output_class <= w_first_idx;
                        end else if (w_step_nxt == r_win_len) begin
                            if (r_mode) begin
                                r_state        <= StDone;
                                r_busy         <= 1'b0;
                                r_end_process  <= 1'b1;
                                r_no_spike     <= 1'b1;
                                r_output_class <= '0;
                            end else begin
                                r_state <= StScan;
                            end
                        end
                    end
                end
                StScan: begin
                    r_best <= w_best_fin;
                    r_max  <= w_max_fin;
                    if (r_scan_idx == LastIdx) begin
                        r_state        <= StDone;
                        r_busy         <= 1'b0;
                        r_end_process  <= 1'b1;
                        r_no_spike     <= (w_max_fin == '0);
                        r_output_class <= w_best_fin;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.end_process  = r_end_process;
    assign bus.output_class = r_output_class;
    assign bus.no_spike     = r_no_spike;

endmodule
